// File: rtl/add16_arb_pkg.sv
// rtl/add16_arb_pkg.sv - shared types, constants and round-robin pick helper for add16_rr_arbiter
package add16_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W      = 16;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);
    localparam int MAX_REQ     = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ID_W-1:0]   id_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Walk offsets from the far end so the nearest valid requester after ptr is written last and wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int                 n);
        pick_t p;
        int    j;
        p = '0;
        for (int off = MAX_REQ - 1; off >= 0; off--) begin
            if (off < n) begin
                j = int'(ptr) + off;
                if (j >= n) begin
                    j = j - n;
                end
                if (valid[j]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/add16_core.sv
// rtl/add16_core.sv - combinational adder producing sum and unsigned carry out
module add16_core #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add16_rr_arbiter.sv
// rtl/add16_rr_arbiter.sv - round-robin shared 16-bit adder; ADD16_ARB_OVF_EN adds rsp_carry/rsp_ovf
module add16_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum
`ifdef ADD16_ARB_OVF_EN
    ,
    output logic                      rsp_carry,
    output logic                      rsp_ovf
`endif
);
    import add16_arb_pkg::*;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    pick_t             pick;
    logic              can_load;
    logic              xfer;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic [DATA_W-1:0] sum_sel;
    logic              carry_sel;
    logic [2:0]        ptr_next;

    assign can_load  = (state == EMPTY) | rsp_ready;
    assign pick      = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), NUM_REQ);
    assign xfer      = pick.found & can_load & ~rst;
    assign rsp_valid = (state == FULL);
    assign ptr_next  = (pick.idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick.idx + 3'd1;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick.idx == 3'(i)) begin
                req_ready[i] = xfer;
                a_sel        = req_a[i*DATA_W +: DATA_W];
                b_sel        = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    add16_core #(.DATA_W(DATA_W)) u_core (
        .a     (a_sel),
        .b     (b_sel),
        .sum   (sum_sel),
        .carry (carry_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            rr_ptr  <= '0;
            rsp_id  <= '0;
            rsp_sum <= '0;
        end else if (xfer) begin
            state   <= FULL;
            rr_ptr  <= ID_W'(ptr_next);
            rsp_id  <= ID_W'(pick.idx);
            rsp_sum <= sum_sel;
        end else if (rsp_ready && state == FULL) begin
            state <= EMPTY;
        end
    end

`ifdef ADD16_ARB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (xfer) begin
            rsp_carry <= carry_sel;
            rsp_ovf   <= (a_sel[DATA_W-1] == b_sel[DATA_W-1]) && (sum_sel[DATA_W-1] != a_sel[DATA_W-1]);
        end
    end
`else
    logic carry_unused;
    assign carry_unused = carry_sel;
`endif

endmodule

// File: tb/tb_add16_rr_arbiter.sv
// tb/tb_add16_rr_arbiter.sv - scoreboard bench for add16_rr_arbiter
module tb_add16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
`ifdef ADD16_ARB_OVF_EN
    logic        rsp_carry;
    logic        rsp_ovf;
`endif

    logic [15:0] op_a [4];
    logic [15:0] op_b [4];

    typedef struct {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    always #5 clk = ~clk;

    add16_rr_arbiter #(.NUM_REQ(4), .DATA_W(16), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef ADD16_ARB_OVF_EN
        ,
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int i);
        exp_t        e;
        logic [16:0] r;
        r       = {1'b0, op_a[i]} + {1'b0, op_b[i]};
        e.id    = 2'(i);
        e.sum   = r[15:0];
        e.carry = r[16];
        e.ovf   = (op_a[i][15] == op_b[i][15]) && (r[15] != op_a[i][15]);
        return e;
    endfunction

    // Retire presented responses first, then record any grant made this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                e = expq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
`ifdef ADD16_ARB_OVF_EN
                check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                expq.push_back(model(i));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end

        step();
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_valid", 32'(rsp_valid), 32'(0));
        check("rst_id", 32'(rsp_id), 32'(0));
        check("rst_sum", 32'(rsp_sum), 32'(0));

        step();
        rst = 1'b0; rsp_ready = 1'b1;
        req_valid = 4'b0001; op_a[0] = 16'h00FF; op_b[0] = 16'h0001;
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'b0001);

        step();
        req_valid = 4'b0010; op_a[1] = 16'hFFFF; op_b[1] = 16'h0002;
        @(negedge clk);
        check("trunc_grant", 32'(req_ready), 32'b0010);
        check("single_rsp_valid", 32'(rsp_valid), 32'(1));

        step();
        req_valid = 4'b0100; op_a[2] = 16'h7FFF; op_b[2] = 16'h0001;
        @(negedge clk);
        check("ovf_grant", 32'(req_ready), 32'b0100);

        step();
        req_valid = 4'b1000; op_a[3] = 16'h4444; op_b[3] = 16'hF000;
        @(negedge clk);
        check("wrap_grant", 32'(req_ready), 32'b1000);

        op_a[0] = 16'h1111; op_b[0] = 16'h0001;
        op_a[1] = 16'h2222; op_b[1] = 16'h0010;
        op_a[2] = 16'h3333; op_b[2] = 16'h0100;
        for (int k = 0; k < 5; k++) begin
            step();
            req_valid = 4'b1111;
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            check("rr_stream", 32'(rsp_valid), 32'(1));
        end

        step();
        @(negedge clk);
        check("bp_first", 32'(req_ready), 32'b0010);
        step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'(0));
            check("bp_valid", 32'(rsp_valid), 32'(1));
            check("bp_id", 32'(rsp_id), 32'(1));
            check("bp_sum", 32'(rsp_sum), 32'h2232);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(req_ready), 32'b0100);

        step();
        req_valid = 4'b0100;
        @(negedge clk);
        check("sparse_wrap", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b1111;
        @(negedge clk);
        check("sparse_ptr", 32'(req_ready), 32'b1000);

        step();
        req_valid = 4'b0010;
        @(negedge clk);
        check("pre_rst_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0000; rsp_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_full", 32'(rsp_valid), 32'(1));
        step();
        rst = 1'b1; req_valid = 4'b1111;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'(0));
        step();
        rst = 1'b0; rsp_ready = 1'b1;
        expq.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_sum", 32'(rsp_sum), 32'(0));
        check("mid_rst_id", 32'(rsp_id), 32'(0));
        check("post_rst_grant", 32'(req_ready), 32'b0001);

        step();
        req_valid = 4'b0000;
        repeat (3) step();
        @(negedge clk);
        check("drain_valid", 32'(rsp_valid), 32'(0));
        check("drain_queue", 32'(expq.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
